// File: rtl/serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_adder: multi-cycle add/subtract, DIGIT bits per clock, LSB first.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int NSLICE = WIDTH / DIGIT;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] C_LAST_SLICE = CNT_W'(NSLICE - 1);

    if (DIGIT < 1 || WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_param
        $fatal(1, "serial_adder: WIDTH must be >= 2 and an exact multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state_q, w_state_d;
    logic [CNT_W-1:0]   r_cnt_q,   w_cnt_d;
    logic [WIDTH-1:0]   r_a_q,     w_a_d;
    logic [WIDTH-1:0]   r_b_q,     w_b_d;
    logic               r_c_q,     w_c_d;
    logic [WIDTH-1:0]   r_sum_q,   w_sum_d;
    logic               r_carry_q, w_carry_d;
    logic               r_ovf_q,   w_ovf_d;
    logic               r_busy_q,  w_busy_d;
    logic               r_done_q,  w_done_d;

    logic [DIGIT-1:0]   w_a_sl;
    logic [DIGIT-1:0]   w_b_sl;
    logic [DIGIT:0]     w_slice;
    logic               w_slice_ovf;

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_a_d     = r_a_q;
        w_b_d     = r_b_q;
        w_c_d     = r_c_q;
        w_sum_d   = r_sum_q;
        w_carry_d = r_carry_q;
        w_ovf_d   = r_ovf_q;

        // Operands shift right each cycle, so the active slice is always the low DIGIT bits.
        w_a_sl  = r_a_q[DIGIT-1:0];
        w_b_sl  = r_b_q[DIGIT-1:0];
        w_slice = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{DIGIT{1'b0}}, r_c_q};
        // Carry into the slice MSB is a^b^s at that bit; XOR with carry-out gives signed overflow.
        w_slice_ovf = w_a_sl[DIGIT-1] ^ w_b_sl[DIGIT-1] ^ w_slice[DIGIT-1] ^ w_slice[DIGIT];

        case (r_state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_a_d     = a;
                    w_b_d     = sub ? ~b : b;
                    w_c_d     = cin ^ sub;
                    w_cnt_d   = '0;
                    w_state_d = S_RUN;
                end else if (r_state_q == S_DONE) begin
                    w_state_d = S_IDLE;
                end
            end
            S_RUN: begin
                w_a_d     = r_a_q >> DIGIT;
                w_b_d     = r_b_q >> DIGIT;
                w_c_d     = w_slice[DIGIT];
                w_sum_d   = (r_sum_q >> DIGIT) | (WIDTH'(w_slice[DIGIT-1:0]) << (WIDTH - DIGIT));
                w_carry_d = w_slice[DIGIT];
                w_ovf_d   = w_slice_ovf;
                if (r_cnt_q == C_LAST_SLICE) begin
                    w_state_d = S_DONE;
                end else begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end
            default: w_state_d = S_IDLE;
        endcase

        w_busy_d = (w_state_d == S_RUN);
        w_done_d = (w_state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_IDLE;
            r_cnt_q   <= '0;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_c_q     <= 1'b0;
            r_sum_q   <= '0;
            r_carry_q <= 1'b0;
            r_ovf_q   <= 1'b0;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_a_q     <= w_a_d;
            r_b_q     <= w_b_d;
            r_c_q     <= w_c_d;
            r_sum_q   <= w_sum_d;
            r_carry_q <= w_carry_d;
            r_ovf_q   <= w_ovf_d;
            r_busy_q  <= w_busy_d;
            r_done_q  <= w_done_d;
        end
    end

    assign busy     = r_busy_q;
    assign done     = r_done_q;
    assign sum      = r_sum_q;
    assign carry    = r_carry_q;
    assign overflow = r_ovf_q;

endmodule
`default_nettype wire
